pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard controller: load-use interlock, multicycle divide wait,
// data-memory back-pressure and exception flush, with a saturating stall counter.
module pipeline_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       id_raddr1_i,
    input  logic [4:0]       id_raddr2_i,
    input  logic             id_re1_i,
    input  logic             id_re2_i,
    input  logic             ex_we_i,
    input  logic [4:0]       ex_waddr_i,
    input  logic             ex_is_load_i,
    input  logic             ex_div_i,
    input  logic             div_ready_i,
    input  logic             dmem_busy_i,
    input  logic             flush_req_i,
    output logic [4:0]       stall_o,
    output logic [4:0]       bubble_o,
    output logic             flush_o,
    output logic             div_start_o,
    output logic             div_cancel_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Handshake note: div_start_o and div_cancel_o are single-cycle strobes;
    // div_ready_i is a single-cycle strobe honoured only while in DIV_WAIT.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_DONE = 2'd2
    } state_t;

    localparam logic [4:0] STALL_LOAD = 5'b00011;
    localparam logic [4:0] BUBBLE_LOAD = 5'b00100;
    localparam logic [4:0] STALL_DIV = 5'b00111;
    localparam logic [4:0] BUBBLE_DIV = 5'b01000;
    localparam logic [4:0] STALL_MEM = 5'b01111;
    localparam logic [4:0] BUBBLE_MEM = 5'b10000;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    state_t state_nxt;
    logic   load_use;
    logic   hit1;
    logic   hit2;

    // Register x0 is hardwired to zero, so a load targeting it is never a hazard.
    assign hit1 = id_re1_i && (id_raddr1_i == ex_waddr_i);
    assign hit2 = id_re2_i && (id_raddr2_i == ex_waddr_i);
    assign load_use = ex_is_load_i && ex_we_i && (ex_waddr_i != 5'd0) && (hit1 || hit2);

    always_comb begin
        stall_o      = 5'b0;
        bubble_o     = 5'b0;
        flush_o      = 1'b0;
        div_start_o  = 1'b0;
        div_cancel_o = 1'b0;
        state_nxt    = state;
        if (!rst_n_i) begin
            state_nxt = IDLE;
        end else if (flush_req_i) begin
            flush_o      = 1'b1;
            div_cancel_o = (state == DIV_WAIT);
            state_nxt    = IDLE;
        end else if (dmem_busy_i) begin
            stall_o  = STALL_MEM;
            bubble_o = BUBBLE_MEM;
            // A ready arriving under back-pressure is parked in DIV_DONE.
            if (state == DIV_WAIT && div_ready_i) begin
                state_nxt = DIV_DONE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ex_div_i) begin
                        div_start_o = 1'b1;
                        stall_o     = STALL_DIV;
                        bubble_o    = BUBBLE_DIV;
                        state_nxt   = DIV_WAIT;
                    end else if (load_use) begin
                        stall_o  = STALL_LOAD;
                        bubble_o = BUBBLE_LOAD;
                    end
                end
                DIV_WAIT: begin
                    if (div_ready_i) begin
                        state_nxt = IDLE;
                    end else begin
                        stall_o  = STALL_DIV;
                        bubble_o = BUBBLE_DIV;
                    end
                end
                DIV_DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            stall_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (stall_o[0] && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: each cycle's expected outputs are
// queued by the driver and checked by an independent negedge monitor.
module tb_pipeline_stall_ctrl;

    localparam int CW = 4;
    localparam int EW = 2 + 5 + 5 + 3 + CW;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [4:0]    id_raddr1_i, id_raddr2_i;
    logic          id_re1_i, id_re2_i;
    logic          ex_we_i, ex_is_load_i, ex_div_i, div_ready_i, dmem_busy_i, flush_req_i;
    logic [4:0]    ex_waddr_i;
    logic [4:0]    stall_o, bubble_o;
    logic          flush_o, div_start_o, div_cancel_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt_o;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    logic [CW-1:0] cnt_model = '0;
    int            checks = 0;
    int            errors = 0;

    pipeline_stall_ctrl #(.CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .id_raddr1_i(id_raddr1_i), .id_raddr2_i(id_raddr2_i),
        .id_re1_i(id_re1_i), .id_re2_i(id_re2_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_is_load_i(ex_is_load_i),
        .ex_div_i(ex_div_i), .div_ready_i(div_ready_i), .dmem_busy_i(dmem_busy_i),
        .flush_req_i(flush_req_i),
        .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
        .div_start_o(div_start_o), .div_cancel_o(div_cancel_o),
        .state_o(state_o), .stall_cnt_o(stall_cnt_o)
    );

    // Clock and reset
    always #5 clk_i = ~clk_i;

    // Driver tasks
    task automatic clear_inputs();
        id_raddr1_i = 5'd0; id_raddr2_i = 5'd0; id_re1_i = 1'b0; id_re2_i = 1'b0;
        ex_we_i = 1'b0; ex_waddr_i = 5'd0; ex_is_load_i = 1'b0; ex_div_i = 1'b0;
        div_ready_i = 1'b0; dmem_busy_i = 1'b0; flush_req_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_load(input logic [4:0] wa, input logic [4:0] a1, input logic r1,
                            input logic [4:0] a2, input logic r2);
        ex_is_load_i = 1'b1; ex_we_i = 1'b1; ex_waddr_i = wa;
        id_raddr1_i = a1; id_re1_i = r1; id_raddr2_i = a2; id_re2_i = r2;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] st, input logic [4:0] stl,
                              input logic [4:0] bub, input logic fl, input logic ds,
                              input logic dc);
        if (!rst_n_i) cnt_model = '0;
        exp_q.push_back({st, stl, bub, fl, ds, dc, cnt_model});
        name_q.push_back(nm);
        if (rst_n_i && stl[0] && cnt_model != {CW{1'b1}}) cnt_model = cnt_model + 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            logic [EW-1:0] a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a = {state_o, stall_o, bubble_o, flush_o, div_start_o, div_cancel_o, stall_cnt_o};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL %s: got st=%0d stall=%b bub=%b fl=%b start=%b cancel=%b cnt=%0d, expected st=%0d stall=%b bub=%b fl=%b start=%b cancel=%b cnt=%0d",
                         nm, a[EW-1 -: 2], a[EW-3 -: 5], a[EW-8 -: 5], a[CW+2], a[CW+1], a[CW],
                         a[CW-1:0], e[EW-1 -: 2], e[EW-3 -: 5], e[EW-8 -: 5], e[CW+2],
                         e[CW+1], e[CW], e[CW-1:0]);
            end
        end
    end

    initial begin
        clear_inputs();
        tick();
        ex_div_i = 1'b1; dmem_busy_i = 1'b1;
        expect_out("reset_outputs", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        rst_n_i = 1'b1;
        expect_out("idle_after_reset", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

        // Load-use interlock
        tick(); set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        expect_out("load_use_addr2", 2'd0, 5'b00011, 5'b00100, 1'b0, 1'b0, 1'b0);
        tick(); clear_inputs();
        expect_out("load_use_release", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        tick(); set_load(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        expect_out("load_use_x0", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        tick(); set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b0);
        expect_out("load_use_re2_off", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        tick(); set_load(5'd7, 5'd7, 1'b1, 5'd3, 1'b1);
        expect_out("load_use_addr1", 2'd0, 5'b00011, 5'b00100, 1'b0, 1'b0, 1'b0);
        tick(); set_load(5'd7, 5'd6, 1'b1, 5'd8, 1'b1);
        expect_out("load_use_nomatch", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        tick(); clear_inputs(); ex_we_i = 1'b1; ex_waddr_i = 5'd9; id_raddr1_i = 5'd9; id_re1_i = 1'b1;
        expect_out("alu_no_interlock", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        tick(); clear_inputs(); div_ready_i = 1'b1;
        expect_out("ready_in_idle", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

        // 33-cycle divide
        tick(); clear_inputs(); ex_div_i = 1'b1;
        expect_out("div_start", 2'd0, 5'b00111, 5'b01000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 10) set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
            else if (i == 11) begin clear_inputs(); ex_div_i = 1'b1; end
            expect_out("div_wait", 2'd1, 5'b00111, 5'b01000, 1'b0, 1'b0, 1'b0);
        end
        tick(); div_ready_i = 1'b1;
        expect_out("div_ready", 2'd1, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        tick(); clear_inputs();
        expect_out("div_back_idle", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

        // Ready coincident with memory back-pressure
        tick(); ex_div_i = 1'b1;
        expect_out("div2_start", 2'd0, 5'b00111, 5'b01000, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("div2_wait", 2'd1, 5'b00111, 5'b01000, 1'b0, 1'b0, 1'b0);
        tick(); div_ready_i = 1'b1; dmem_busy_i = 1'b1;
        expect_out("ready_busy", 2'd1, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(); div_ready_i = 1'b0;
            expect_out("div_done_busy", 2'd2, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0);
        end
        tick(); dmem_busy_i = 1'b0; set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        expect_out("div_done_release", 2'd2, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        tick(); clear_inputs();
        expect_out("div_done_idle", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

        // Flush handling and priority
        tick(); ex_div_i = 1'b1;
        expect_out("div3_start", 2'd0, 5'b00111, 5'b01000, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("div3_wait", 2'd1, 5'b00111, 5'b01000, 1'b0, 1'b0, 1'b0);
        tick(); flush_req_i = 1'b1; dmem_busy_i = 1'b1;
        expect_out("flush_in_wait", 2'd1, 5'b0, 5'b0, 1'b1, 1'b0, 1'b1);
        tick(); clear_inputs();
        expect_out("flush_to_idle", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        tick(); flush_req_i = 1'b1; set_load(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
        expect_out("flush_in_idle", 2'd0, 5'b0, 5'b0, 1'b1, 1'b0, 1'b0);
        tick(); clear_inputs(); dmem_busy_i = 1'b1; ex_div_i = 1'b1;
        expect_out("busy_blocks_start", 2'd0, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0);
        tick(); dmem_busy_i = 1'b0;
        expect_out("start_after_busy", 2'd0, 5'b00111, 5'b01000, 1'b0, 1'b1, 1'b0);
        tick(); dmem_busy_i = 1'b1;
        expect_out("busy_in_wait", 2'd1, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0);
        tick(); dmem_busy_i = 1'b0;
        expect_out("wait_after_busy", 2'd1, 5'b00111, 5'b01000, 1'b0, 1'b0, 1'b0);

        // Reset mid-divide, then normal evaluation from IDLE
        tick(); rst_n_i = 1'b0;
        expect_out("reset_mid_div", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
        tick(); rst_n_i = 1'b1;
        expect_out("restart_after_reset", 2'd0, 5'b00111, 5'b01000, 1'b0, 1'b1, 1'b0);
        tick(); clear_inputs(); flush_req_i = 1'b1;
        expect_out("cancel_after_restart", 2'd1, 5'b0, 5'b0, 1'b1, 1'b0, 1'b1);

        // Counter saturation: 2^CW + 5 stall cycles
        tick(); clear_inputs(); dmem_busy_i = 1'b1;
        for (int i = 0; i < (1 << CW) + 5; i++) begin
            if (i > 0) tick();
            expect_out("cnt_saturate", 2'd0, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0);
        end
        tick(); clear_inputs();
        expect_out("cnt_hold_max", 2'd0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
        if (exp_q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
